// File: rtl/sqrt_sweep_initiator.sv
// Sweeps a range of 16-bit operands through a start/done square-root unit and checks each
// returned root with a shift-add squarer. Optional WAIT timeout: SQRT_SWEEP_TIMEOUT_EN.
`timescale 1ns/1ps
module sqrt_sweep_initiator #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        go,
   input  logic [15:0] first,
   input  logic [15:0] last,
   output logic        busy,
   output logic        finished,
   output logic [15:0] pass_count,
   output logic [15:0] fail_count,
   output logic [15:0] fail_value,
   output logic        timeout_seen,
   output logic        sqrt_start,
   output logic [15:0] sqrt_in,
   input  logic [7:0]  sqrt_out,
   input  logic        sqrt_error,
   input  logic        sqrt_done
);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, SQUARE, CHECK, DONE} state_t;

   state_t      state;
   logic [15:0] value;
   logic [15:0] last_q;
   logic [7:0]  r;
   logic        e;
   logic [15:0] p;
   logic [15:0] mcand;
   logic [7:0]  mplier;
   logic [2:0]  sq_cnt;
   logic        wait_armed;
   logic [16:0] q;
   logic        pass;

`ifdef SQRT_SWEEP_TIMEOUT_EN
   localparam int WCW = $clog2(TIMEOUT_CYCLES + 1);
   logic [WCW-1:0] wait_cnt;
   logic           timed_out;
`else
   assign timeout_seen = 1'b0;
`endif

   // Upper bound of the accepted root window: (r+1)^2 = r^2 + 2r + 1.
   assign q = {1'b0, p} + {8'b0, r, 1'b0} + 17'd1;

   // NOTE: pass gets a default before any branch, so this block can never infer a latch.
   always_comb begin
      pass = 1'b0;
      if (value[15])
         pass = e;
      else
         pass = !e && (p <= value) && (q > {1'b0, value});
`ifdef SQRT_SWEEP_TIMEOUT_EN
      if (timed_out)
         pass = 1'b0;
`endif
   end

   // NOTE: all state uses non-blocking assignments so every register updates from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         value      <= '0;
         last_q     <= '0;
         r          <= '0;
         e          <= 1'b0;
         p          <= '0;
         mcand      <= '0;
         mplier     <= '0;
         sq_cnt     <= '0;
         wait_armed <= 1'b0;
         busy       <= 1'b0;
         finished   <= 1'b0;
         pass_count <= '0;
         fail_count <= '0;
         fail_value <= '0;
         sqrt_start <= 1'b0;
         sqrt_in    <= '0;
`ifdef SQRT_SWEEP_TIMEOUT_EN
         wait_cnt     <= '0;
         timed_out    <= 1'b0;
         timeout_seen <= 1'b0;
`endif
      end else begin
         sqrt_start <= 1'b0;
         finished   <= 1'b0;
         unique case (state)
            IDLE: begin
               if (go) begin
                  value      <= first;
                  last_q     <= last;
                  pass_count <= '0;
                  fail_count <= '0;
                  fail_value <= '0;
                  busy       <= 1'b1;
                  sqrt_start <= 1'b1;
                  sqrt_in    <= first;
                  state      <= ISSUE;
`ifdef SQRT_SWEEP_TIMEOUT_EN
                  timeout_seen <= 1'b0;
`endif
               end
            end
            ISSUE: begin
               wait_armed <= 1'b0;
`ifdef SQRT_SWEEP_TIMEOUT_EN
               wait_cnt  <= '0;
               timed_out <= 1'b0;
`endif
               state <= WAIT;
            end
            WAIT: begin
               // The first WAIT cycle only arms the capture; a done level left from
               // the previous request must not be taken as this request's answer.
               wait_armed <= 1'b1;
               if (wait_armed && sqrt_done) begin
                  r      <= sqrt_out;
                  e      <= sqrt_error;
                  p      <= '0;
                  mcand  <= {8'b0, sqrt_out};
                  mplier <= sqrt_out;
                  sq_cnt <= '0;
                  state  <= SQUARE;
               end
`ifdef SQRT_SWEEP_TIMEOUT_EN
               else if (wait_cnt == WCW'(TIMEOUT_CYCLES - 1)) begin
                  timed_out    <= 1'b1;
                  timeout_seen <= 1'b1;
                  state        <= CHECK;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
`endif
            end
            SQUARE: begin
               if (mplier[0])
                  p <= p + mcand;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               sq_cnt <= sq_cnt + 3'd1;
               if (sq_cnt == 3'd7)
                  state <= CHECK;
            end
            CHECK: begin
               if (pass) begin
                  if (pass_count != 16'hFFFF)
                     pass_count <= pass_count + 16'd1;
               end else begin
                  if (fail_count != 16'hFFFF)
                     fail_count <= fail_count + 16'd1;
                  fail_value <= value;
               end
               if (value == last_q) begin
                  busy     <= 1'b0;
                  finished <= 1'b1;
                  state    <= DONE;
               end else begin
                  value      <= value + 16'd1;
                  sqrt_in    <= value + 16'd1;
                  sqrt_start <= 1'b1;
                  state      <= ISSUE;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sqrt_sweep_initiator.sv
// Randomized self-checking bench: a behavioural square-root responder plus a sweep-level
// reference model predicting request order, pass/fail totals and the last failing value.
`timescale 1ns/1ps
module tb_sqrt_sweep_initiator;

   localparam int M_OK    = 0;
   localparam int M_NOERR = 1;
   localparam int M_F24   = 2;
   localparam int M_RAND  = 3;
   localparam int M_NEVER = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        go;
   logic [15:0] first, last;
   logic        busy, finished, timeout_seen, sqrt_start;
   logic [15:0] pass_count, fail_count, fail_value, sqrt_in;
   logic [7:0]  sqrt_out;
   logic        sqrt_error, sqrt_done;

   int n_checks = 0;
   int n_pass   = 0;

   int          mode = M_OK;
   bit          level_mode = 1'b0;
   int unsigned corrupt_seed = 0;
   logic [15:0] sw_first, sw_last;
   int          sw_n;
   logic [15:0] exp_q[$];
   int          exp_pass, exp_fail;
   logic [15:0] exp_fv;
   bit          exp_to;
   int          fin_cnt = 0;
   logic [15:0] cmp_v;

   sqrt_sweep_initiator #(.TIMEOUT_CYCLES(64)) dut (
      .clk(clk), .rst(rst), .go(go), .first(first), .last(last),
      .busy(busy), .finished(finished), .pass_count(pass_count), .fail_count(fail_count),
      .fail_value(fail_value), .timeout_seen(timeout_seen), .sqrt_start(sqrt_start),
      .sqrt_in(sqrt_in), .sqrt_out(sqrt_out), .sqrt_error(sqrt_error), .sqrt_done(sqrt_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic int isqrt(input int v);
      int s = 0;
      while ((s + 1) * (s + 1) <= v) s++;
      return s;
   endfunction

   // Returns {root, error} that the square-root unit under a given mode hands back.
   function automatic logic [8:0] model_resp(input logic [15:0] v, input int m, input int unsigned seed);
      int  s;
      logic e;
      if (v[15]) return (m == M_NOERR) ? 9'd0 : 9'd1;
      s = isqrt(int'(v));
      e = 1'b0;
      if (m == M_F24 && v == 16'd24) s = 5;
      if (m == M_RAND && ((int'(v) ^ seed) & 3) == 0) s = s + 1;
      if (m == M_RAND && ((int'(v) ^ seed) & 7) == 5) e = 1'b1;
      return {s[7:0], e};
   endfunction

   function automatic bit spec_pass(input logic [15:0] v, input logic [7:0] s, input logic e);
      if (v[15]) return e;
      return !e && (int'(s) * int'(s) <= int'(v)) && ((int'(s) + 1) * (int'(s) + 1) > int'(v));
   endfunction

   // Square-root unit stand-in: answers no earlier than the second WAIT cycle; in level
   // mode the previous answer stays on the bus until then, exercising the stale-done guard.
   initial begin : responder
      logic [15:0] op;
      int ticks, delay;
      bit pend;
      logic [8:0] rsp;
      sqrt_done = 1'b0; sqrt_out = '0; sqrt_error = 1'b0; pend = 1'b0;
      op = '0; ticks = 0; delay = 1;
      forever begin
         @(posedge clk); #1;
         if (rst) begin
            sqrt_done = 1'b0; sqrt_out = '0; sqrt_error = 1'b0; pend = 1'b0;
         end else if (sqrt_start) begin
            pend = 1'b1; ticks = 0; delay = $urandom_range(1, 4); op = sqrt_in;
            if (!level_mode || mode == M_NEVER) sqrt_done = 1'b0;
         end else if (pend) begin
            ticks++;
            if (ticks == 1) begin
               if (!level_mode) sqrt_done = 1'b0;
            end else if (mode == M_NEVER) begin
               sqrt_done = 1'b0;
            end else if (ticks - 1 >= delay) begin
               rsp = model_resp(op, mode, corrupt_seed);
               sqrt_out = rsp[8:1]; sqrt_error = rsp[0]; sqrt_done = 1'b1; pend = 1'b0;
            end else begin
               sqrt_done = 1'b0;
            end
         end else if (!level_mode) begin
            sqrt_done = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (sqrt_start) begin
            if (exp_q.size() == 0) check("unexpected_request", 32'(sqrt_in), 32'hDEAD);
            else begin
               cmp_v = exp_q.pop_front();
               check("sqrt_in_order", 32'(sqrt_in), 32'(cmp_v));
            end
            check("busy_during_issue", 32'(busy), 1);
         end
         if (finished) begin
            fin_cnt++;
            check("pass_count", 32'(pass_count), 32'(exp_pass));
            check("fail_count", 32'(fail_count), 32'(exp_fail));
            check("fail_value", 32'(fail_value), 32'(exp_fv));
            check("timeout_seen", 32'(timeout_seen), 32'(exp_to));
            check("busy_low_at_finish", 32'(busy), 0);
            check("requests_outstanding", 32'(exp_q.size()), 0);
         end
      end
   end

   task automatic prep(input logic [15:0] f, input logic [15:0] l, input int m);
      logic [15:0] d, v;
      logic [8:0]  rsp;
      bit ok;
      sw_first = f; sw_last = l; mode = m;
      corrupt_seed = $urandom; level_mode = 1'($urandom_range(0, 1));
      exp_q.delete();
      d = l - f;
      sw_n = int'(d) + 1;
      exp_pass = 0; exp_fail = 0; exp_fv = '0;
      for (int i = 0; i < sw_n; i++) begin
         v = 16'(int'(f) + i);
         exp_q.push_back(v);
         rsp = model_resp(v, m, corrupt_seed);
         ok = (m == M_NEVER) ? 1'b0 : spec_pass(v, rsp[8:1], rsp[0]);
         if (ok) begin
            if (exp_pass < 65535) exp_pass++;
         end else begin
            if (exp_fail < 65535) exp_fail++;
            exp_fv = v;
         end
      end
      exp_to = (m == M_NEVER);
   endtask

   task automatic launch();
      @(negedge clk);
      first = sw_first; last = sw_last; go = 1'b1;
      @(posedge clk); #1;
      go = 1'b0;
      check("start_latency", 32'(sqrt_start), 1);
      check("busy_after_go", 32'(busy), 1);
   endtask

   task automatic finish_wait(input int lp, input int lf, input int lfv, input bit noise);
      int start = fin_cnt;
      int limit = sw_n * ((mode == M_NEVER) ? 80 : 30) + 40;
      bit got = 1'b0;
      for (int c = 0; c < limit; c++) begin
         @(negedge clk); #1;
         if (fin_cnt != start) begin got = 1'b1; break; end
         if (noise && c == 7) begin
            go = 1'b1; first = 16'($urandom); last = 16'($urandom);
         end else go = 1'b0;
      end
      go = 1'b0;
      if (!got) begin
         check("sweep_completed", 0, 1);
         rst = 1'b1; exp_q.delete();
         repeat (2) @(negedge clk);
         #2 rst = 1'b0;
      end
      if (lp >= 0) begin
         check("literal_pass", 32'(pass_count), 32'(lp));
         check("literal_fail", 32'(fail_count), 32'(lf));
         check("literal_fail_value", 32'(fail_value), 32'(lfv));
      end
   endtask

   initial begin : main
      logic [15:0] f;
      rst = 1'b1; go = 1'b0; first = '0; last = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 0);
      check("rst_finished", 32'(finished), 0);
      check("rst_pass", 32'(pass_count), 0);
      check("rst_fail", 32'(fail_count), 0);
      check("rst_fail_value", 32'(fail_value), 0);
      check("rst_timeout", 32'(timeout_seen), 0);
      check("rst_start", 32'(sqrt_start), 0);
      check("rst_sqrt_in", 32'(sqrt_in), 0);
      #2 rst = 1'b0;

      check("model_isqrt16", 32'(isqrt(16)), 4);
      check("model_isqrt24", 32'(isqrt(24)), 4);
      check("model_root5_of_24", 32'(spec_pass(16'd24, 8'd5, 1'b0)), 0);
      check("model_neg_err", 32'(spec_pass(16'h8000, 8'd0, 1'b1)), 1);

      prep(16'd16, 16'd16, M_OK);        launch(); finish_wait(1, 0, 0, 1'b0);
      prep(16'd0, 16'd255, M_OK);        launch(); finish_wait(256, 0, 0, 1'b1);
      prep(16'h8000, 16'h8003, M_OK);    launch(); finish_wait(4, 0, 0, 1'b0);
      prep(16'h8000, 16'h8003, M_NOERR); launch(); finish_wait(0, 4, 16'h8003, 1'b0);
      prep(16'd20, 16'd30, M_F24);       launch(); finish_wait(10, 1, 24, 1'b0);
      prep(16'hFFFE, 16'h0001, M_OK);    launch(); finish_wait(4, 0, 0, 1'b0);

      // go raised during DONE is ignored there and taken one cycle later in IDLE.
      prep(16'd9, 16'd9, M_OK);
      first = 16'd9; last = 16'd9; go = 1'b1;
      @(posedge clk); #1;
      check("go_in_done_ignored", 32'(sqrt_start), 0);
      check("idle_after_done", 32'(busy), 0);
      @(posedge clk); #1;
      go = 1'b0;
      check("go_taken_in_idle", 32'(sqrt_start), 1);
      finish_wait(1, 0, 0, 1'b0);

      repeat (12) begin
         f = 16'($urandom);
         prep(f, f + 16'($urandom_range(0, 12)), $urandom_range(0, 3));
         launch();
         finish_wait(-1, -1, -1, 1'($urandom_range(0, 1)));
      end

      prep(16'd0, 16'd100, M_OK);
      launch();
      repeat (30) @(negedge clk);
      check("progress_before_reset", 32'(pass_count != 0), 1);
      #2 rst = 1'b1;
      #1;
      check("midrst_busy", 32'(busy), 0);
      check("midrst_finished", 32'(finished), 0);
      check("midrst_pass", 32'(pass_count), 0);
      check("midrst_fail", 32'(fail_count), 0);
      check("midrst_fail_value", 32'(fail_value), 0);
      check("midrst_timeout", 32'(timeout_seen), 0);
      check("midrst_start", 32'(sqrt_start), 0);
      check("midrst_sqrt_in", 32'(sqrt_in), 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      prep(16'd100, 16'd103, M_OK); launch(); finish_wait(4, 0, 0, 1'b0);

`ifdef SQRT_SWEEP_TIMEOUT_EN
      prep(16'd5, 16'd6, M_NEVER); launch(); finish_wait(0, 2, 6, 1'b0);
      check("timeout_sticky", 32'(timeout_seen), 1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/sqrt_sweep_initiator.md
# sqrt_sweep_initiator

Requester-side driver and checker for the `sqrt_calculator` start/done handshake. It sweeps a range of 16-bit inputs into the square-root unit, one request at a time. Each returned root or error flag is checked with an internal sequential shift-add squarer. Pass and fail totals are accumulated for self-test of the square-root datapath.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 64: maximum WAIT cycles per request. Used only with `SQRT_SWEEP_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `go` in 1: start a sweep. Sampled only in IDLE.
- `first` in 16: first input value. Sampled on `go`.
- `last` in 16: final input value. Sampled on `go`.
- `busy` out 1: high from the cycle after `go` is accepted through the final CHECK.
- `finished` out 1: one-cycle pulse when the sweep completes.
- `pass_count` out 16: number of passing tests. Saturates at 0xFFFF.
- `fail_count` out 16: number of failing tests. Saturates at 0xFFFF.
- `fail_value` out 16: input value of the most recent failing test.
- `timeout_seen` out 1: sticky flag. Cleared on `go` accept.
- `sqrt_start` out 1: one-cycle request pulse to the square-root unit.
- `sqrt_in` out 16: request operand. Held stable from ISSUE until the request is consumed.
- `sqrt_out` in 8: returned root.
- `sqrt_error` in 1: returned error flag.
- `sqrt_done` in 1: completion signal from the square-root unit, level or pulse.

## Operation
FSM states: IDLE, ISSUE, WAIT, SQUARE, CHECK, DONE.

- **IDLE**
  - If `go`=1: latch `first` into `value` and `last` into `last_q`; clear both counters, `fail_value` and `timeout_seen`; go to ISSUE.
- **ISSUE**
  - `sqrt_start`=1 for this cycle, `sqrt_in`=`value`; go to WAIT.
- **WAIT**
  - `sqrt_done` is ignored in the first WAIT cycle, which guards against a stale done level.
  - From the second WAIT cycle on, the first cycle with `sqrt_done`=1 captures `r`=`sqrt_out` and `e`=`sqrt_error`, then goes to SQUARE.
- **SQUARE**
  - 8 cycles of shift-add computing p = r*r (16 bits).
  - Then q = p + 2r + 1 (17 bits) is formed.
- **CHECK** (1 cycle)
  - If `value[15]`=1 (negative as signed): pass iff `e`=1; `r` is ignored.
  - Otherwise: pass iff `e`=0 and p ≤ `value` and q > `value`, compared unsigned with q zero-extended.
  - On fail, `fail_value` takes `value`.
  - If `value`==`last_q`, go to DONE.
  - Otherwise `value` increments modulo 2^16 and the FSM goes to ISSUE.
- **DONE**
  - `finished`=1 for one cycle; return to IDLE.

Boundary cases:
- `first`==`last`: exactly one test.
- `first`>`last`: the sweep wraps from 0xFFFF to 0x0000.
- `first`=0, `last`=0xFFFF: 65536 tests; counters saturate.
- `go` while busy: ignored.
- `go` in the same cycle as DONE: ignored. It is accepted the next cycle, in IDLE.
- `rst` mid-sweep: every output returns to its reset value immediately. The square-root unit shares `rst`.

## Timing
- Reset values: all outputs 0; state IDLE.
- `go` accept to first `sqrt_start`: 1 cycle.
- Per test: 1 (ISSUE) + N (WAIT, N ≥ 2) + 8 (SQUARE) + 1 (CHECK) = 10+N cycles.
- Counters and `fail_value` update on the CHECK clock edge.
- `finished` is asserted the cycle after the last CHECK.
- `busy` falls in the same cycle that `finished` rises.

## Configuration
- `SQRT_SWEEP_TIMEOUT_EN` defined:
  - A WAIT counter runs from WAIT entry.
  - If `TIMEOUT_CYCLES` WAIT cycles pass with no accepted `sqrt_done`, the test is counted as fail and `fail_value`=`value`.
  - `timeout_seen` is set and the FSM goes straight to CHECK-advance (SQUARE is skipped).
- `SQRT_SWEEP_TIMEOUT_EN` undefined:
  - WAIT waits indefinitely.
  - `timeout_seen` is tied to 0 and `TIMEOUT_CYCLES` is unused.

## Test plan
- `first`=`last`=16, correct model returns 4 → one `sqrt_start` with `sqrt_in`=16; `pass_count`=1, `fail_count`=0; one `finished` pulse.
- `first`=0, `last`=255, correct model → 256 requests in ascending order; `pass_count`=256, `fail_count`=0.
- `first`=0x8000, `last`=0x8003, model asserts error → `pass_count`=4. Repeat with a model that does not assert error → `fail_count`=4, `fail_value`=0x8003.
- Faulty model returns 5 for input 24, correct elsewhere; sweep 20..30 → `pass_count`=10, `fail_count`=1, `fail_value`=24.
- `first`=0xFFFE, `last`=0x0001 → request order FFFE, FFFF, 0000, 0001; 4 tests; `finished` pulses once.
- With `SQRT_SWEEP_TIMEOUT_EN`, `TIMEOUT_CYCLES`=64, model never returns done → each test fails after 64 WAIT cycles and `timeout_seen`=1. Asserting `rst` mid-sweep → all outputs 0 and `sqrt_start` low.
